// File: rtl/inst_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_dispatch_ctrl
//
// Instruction queue and dispatch sequencer that sits between the fetcher and
// the out-of-order back end. Fetched words are buffered in a circular FIFO.
// The head word goes to an external combinational decoder, and one instruction
// per cycle is issued to the reservation station (RS) or the load/store buffer
// (LSB). A rollback from the ROB discards all queued work.
//
// Optional build macro: DISPATCH_STALL_CNT_EN adds the stall, illegal-pop and
// flush statistic counters.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   rdy_in                  global pause; low freezes every register
//   rollback_in             flush request from the ROB
//   fetch_*_in              push request with {inst, pc, predicted-taken}
//   iq_full_out             backpressure to the fetcher (count >= DEPTH-MARGIN)
//   dec_inst_out            head word to the decoder (0 while empty)
//   dec_op_enum_in          decoder op enum, 0 = illegal
//   dec_is_load/store_in    decoder memory classification of the head word
//   rob/rs/lsb_full_in      back-end capacity flags
//   issue_*_out             registered one-cycle issue strobe and payload
//   stall_cnt_out           (optional) cycles spent in S_STALL
//   illegal_cnt_out         (optional) discarded enum-0 pops
//   flush_cnt_out           (optional) rollbacks taken
// -----------------------------------------------------------------------------
module inst_dispatch_ctrl #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned FULL_MARGIN = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        rollback_in,
    input  logic        fetch_valid_in,
    input  logic [31:0] fetch_inst_in,
    input  logic [31:0] fetch_pc_in,
    input  logic        fetch_pred_jump_in,
    output logic        iq_full_out,
    output logic [31:0] dec_inst_out,
    input  logic [5:0]  dec_op_enum_in,
    input  logic        dec_is_load_in,
    input  logic        dec_is_store_in,
    input  logic        rob_full_in,
    input  logic        rs_full_in,
    input  logic        lsb_full_in,
    output logic        issue_valid_out,
    output logic        issue_to_lsb_out,
    output logic [31:0] issue_inst_out,
    output logic [31:0] issue_pc_out,
    output logic        issue_pred_jump_out
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_out,
    output logic [15:0] illegal_cnt_out,
    output logic [15:0] flush_cnt_out
`endif
);

    localparam int unsigned     DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] FULL_TH = (ADDR_W + 1)'(DEPTH - FULL_MARGIN);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_RUN,
        S_STALL,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Payload storage
    logic [31:0] r_inst_mem [DEPTH];
    logic [31:0] r_pc_mem   [DEPTH];
    logic        r_pred_mem [DEPTH];

    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;

    logic w_is_mem;
    logic w_ok;
    logic w_push;
    logic w_pop;

    // Head-of-queue dispatch decision
    assign w_is_mem = dec_is_load_in | dec_is_store_in;
    assign w_ok     = !rob_full_in && (w_is_mem ? !lsb_full_in : !rs_full_in);

    // A push at a full queue is dropped even if a pop frees a slot in the same
    // cycle, so the write never depends on the back-end flags.
    assign w_push = rdy_in && fetch_valid_in && (r_count < CNT_MAX) &&
                    !rollback_in && (r_state != S_FLUSH);
    assign w_pop  = rdy_in && (r_count != '0) && (r_state != S_FLUSH) &&
                    !rollback_in && w_ok;

    assign iq_full_out  = (r_count >= FULL_TH);
    assign dec_inst_out = (r_count == '0) ? '0 : r_inst_mem[r_head];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (ADDR_W + 1)'(1);
            2'b01:   w_count_nxt = r_count - (ADDR_W + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (rdy_in) begin
            if (rollback_in) begin
                w_state_nxt = S_FLUSH;
            end else begin
                case (r_state)
                    S_FLUSH: w_state_nxt = S_EMPTY;
                    S_EMPTY: begin
                        if (w_push) begin
                            w_state_nxt = S_RUN;
                        end
                    end
                    S_RUN, S_STALL: begin
                        if (w_count_nxt == '0) begin
                            w_state_nxt = S_EMPTY;
                        end else if (!w_ok) begin
                            w_state_nxt = S_STALL;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
                    end
                    default: w_state_nxt = S_EMPTY;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage write port (no reset: occupancy is tracked by r_count)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_inst_mem[r_tail] <= fetch_inst_in;
            r_pc_mem[r_tail]   <= fetch_pc_in;
            r_pred_mem[r_tail] <= fetch_pred_jump_in;
        end
    end

    // ---------------------------------------------------------------------
    // Pointers, occupancy and issue register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head              <= '0;
            r_tail              <= '0;
            r_count             <= '0;
            issue_valid_out     <= 1'b0;
            issue_to_lsb_out    <= 1'b0;
            issue_inst_out      <= '0;
            issue_pc_out        <= '0;
            issue_pred_jump_out <= 1'b0;
        end else if (rdy_in) begin
            if (rollback_in) begin
                r_head          <= '0;
                r_tail          <= '0;
                r_count         <= '0;
                issue_valid_out <= 1'b0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + ADDR_W'(1);
                end
                if (w_pop) begin
                    r_head              <= r_head + ADDR_W'(1);
                    // Illegal ops leave the queue but never reach the back end
                    issue_valid_out     <= (dec_op_enum_in != '0);
                    issue_to_lsb_out    <= w_is_mem;
                    issue_inst_out      <= r_inst_mem[r_head];
                    issue_pc_out        <= r_pc_mem[r_head];
                    issue_pred_jump_out <= r_pred_mem[r_head];
                end else begin
                    issue_valid_out <= 1'b0;
                end
                r_count <= w_count_nxt;
            end
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating statistics counters
    // ---------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [15:0] r_illegal_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_stall_cnt   <= '0;
            r_illegal_cnt <= '0;
            r_flush_cnt   <= '0;
        end else if (rdy_in) begin
            if ((r_state == S_STALL) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_pop && (dec_op_enum_in == '0) && (r_illegal_cnt != '1)) begin
                r_illegal_cnt <= r_illegal_cnt + 16'd1;
            end
            if (rollback_in && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt_out   = r_stall_cnt;
    assign illegal_cnt_out = r_illegal_cnt;
    assign flush_cnt_out   = r_flush_cnt;
`endif

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_dispatch_ctrl
//
// Directed bench for inst_dispatch_ctrl. A small decoder model drives the
// decoder inputs from dec_inst_out. Every accepted legal push records its
// expected issue in a scoreboard queue; the negedge monitor pops and compares
// each issue strobe. Directed checks cover reset, backpressure, stalls,
// rollback, illegal ops, pause and mid-run reset.
// -----------------------------------------------------------------------------
module tb_inst_dispatch_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        rollback_in = 1'b0;
    logic        fetch_valid_in = 1'b0;
    logic [31:0] fetch_inst_in = '0;
    logic [31:0] fetch_pc_in = '0;
    logic        fetch_pred_jump_in = 1'b0;
    logic        iq_full_out;
    logic [31:0] dec_inst_out;
    logic [5:0]  dec_op_enum_in;
    logic        dec_is_load_in;
    logic        dec_is_store_in;
    logic        rob_full_in = 1'b0;
    logic        rs_full_in = 1'b0;
    logic        lsb_full_in = 1'b0;
    logic        issue_valid_out;
    logic        issue_to_lsb_out;
    logic [31:0] issue_inst_out;
    logic [31:0] issue_pc_out;
    logic        issue_pred_jump_out;
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt_out;
    logic [15:0] illegal_cnt_out;
    logic [15:0] flush_cnt_out;
`endif

    always #5 clk_in = ~clk_in;

    inst_dispatch_ctrl #(
        .ADDR_W      (4),
        .FULL_MARGIN (1)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .rdy_in              (rdy_in),
        .rollback_in         (rollback_in),
        .fetch_valid_in      (fetch_valid_in),
        .fetch_inst_in       (fetch_inst_in),
        .fetch_pc_in         (fetch_pc_in),
        .fetch_pred_jump_in  (fetch_pred_jump_in),
        .iq_full_out         (iq_full_out),
        .dec_inst_out        (dec_inst_out),
        .dec_op_enum_in      (dec_op_enum_in),
        .dec_is_load_in      (dec_is_load_in),
        .dec_is_store_in     (dec_is_store_in),
        .rob_full_in         (rob_full_in),
        .rs_full_in          (rs_full_in),
        .lsb_full_in         (lsb_full_in),
        .issue_valid_out     (issue_valid_out),
        .issue_to_lsb_out    (issue_to_lsb_out),
        .issue_inst_out      (issue_inst_out),
        .issue_pc_out        (issue_pc_out),
        .issue_pred_jump_out (issue_pred_jump_out)
`ifdef DISPATCH_STALL_CNT_EN
        ,
        .stall_cnt_out       (stall_cnt_out),
        .illegal_cnt_out     (illegal_cnt_out),
        .flush_cnt_out       (flush_cnt_out)
`endif
    );

    // Decoder model: all-zero word is illegal, opcode 0x03 load, 0x23 store
    logic [6:0] w_opc;
    assign w_opc           = dec_inst_out[6:0];
    assign dec_is_load_in  = (dec_inst_out != '0) && (w_opc == 7'h03);
    assign dec_is_store_in = (dec_inst_out != '0) && (w_opc == 7'h23);
    assign dec_op_enum_in  = (dec_inst_out == '0) ? 6'd0 :
                             dec_is_load_in  ? 6'd10 :
                             dec_is_store_in ? 6'd20 : 6'd1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
        logic        lsb;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic rdy_q = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_word(input int unsigned imm);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push1(input logic [31:0] inst, input logic [31:0] pc,
                         input logic pred, input bit accept);
        exp_t e;
        fetch_valid_in     = 1'b1;
        fetch_inst_in      = inst;
        fetch_pc_in        = pc;
        fetch_pred_jump_in = pred;
        if (accept && (inst != '0)) begin
            e.inst = inst;
            e.pc   = pc;
            e.pred = pred;
            e.lsb  = (inst[6:0] == 7'h03) || (inst[6:0] == 7'h23);
            sbq.push_back(e);
        end
        tick();
        fetch_valid_in = 1'b0;
    endtask

    // Issue monitor: only edges taken with rdy_in high produce a new issue
    always @(posedge clk_in) rdy_q <= rdy_in;

    always @(negedge clk_in) begin
        if (rst_n_in && rdy_q && issue_valid_out) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_issue observed=pc %h expected=no issue", issue_pc_out);
            end else begin
                mon_e = sbq.pop_front();
                chk("issue_inst", issue_inst_out, mon_e.inst);
                chk("issue_pc", issue_pc_out, mon_e.pc);
                chk("issue_pred", {31'd0, issue_pred_jump_out}, {31'd0, mon_e.pred});
                chk("issue_lsb", {31'd0, issue_to_lsb_out}, {31'd0, mon_e.lsb});
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        #1 rst_n_in = 1'b0;
        #2;
        chk("rst_valid", {31'd0, issue_valid_out}, 32'd0);
        chk("rst_full", {31'd0, iq_full_out}, 32'd0);
        chk("rst_dec", dec_inst_out, 32'd0);
        chk("rst_inst", issue_inst_out, 32'd0);
        chk("rst_pc", issue_pc_out, 32'd0);
        tick();
        tick();
        rst_n_in = 1'b1;

        // ---------------- three ALU words back to back ----------------
        push1(alu_word(1), 32'h0, 1'b0, 1'b1);
        chk("t1_dec_head", dec_inst_out, alu_word(1));
        chk("t1_no_issue_yet", {31'd0, issue_valid_out}, 32'd0);
        push1(alu_word(2), 32'h4, 1'b1, 1'b1);
        chk("t1_issue0", {31'd0, issue_valid_out}, 32'd1);
        push1(alu_word(3), 32'h8, 1'b0, 1'b1);
        chk("t1_issue1", {31'd0, issue_valid_out}, 32'd1);
        tick();
        chk("t1_issue2", {31'd0, issue_valid_out}, 32'd1);
        chk("t1_dec_empty", dec_inst_out, 32'd0);
        tick();
        chk("t1_idle", {31'd0, issue_valid_out}, 32'd0);

        // ---------------- fill to 16, drop 17th, drain with wrap ----------------
        rs_full_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push1(alu_word(32'h100 + i), 32'h100 + 4 * i, i[0], 1'b1);
            if (i == 13) chk("t2_not_full_14", {31'd0, iq_full_out}, 32'd0);
            if (i == 14) chk("t2_full_15", {31'd0, iq_full_out}, 32'd1);
            chk("t2_no_issue", {31'd0, issue_valid_out}, 32'd0);
        end
        push1(alu_word(32'h7ff), 32'h1000, 1'b0, 1'b0);
        chk("t2_full_16", {31'd0, iq_full_out}, 32'd1);
        chk("t2_head_held", dec_inst_out, alu_word(32'h100));
        rs_full_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("t2_drain_valid", {31'd0, issue_valid_out}, 32'd1);
        end
        tick();
        chk("t2_drained", {31'd0, issue_valid_out}, 32'd0);
        chk("t2_full_clear", {31'd0, iq_full_out}, 32'd0);
        chk("t2_dec_empty", dec_inst_out, 32'd0);

        // ---------------- load blocked by LSB ----------------
        lsb_full_in = 1'b1;
        push1(32'h0000a103, 32'h200, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_valid", {31'd0, issue_valid_out}, 32'd0);
            chk("t3_stall_head", dec_inst_out, 32'h0000a103);
        end
        lsb_full_in = 1'b0;
        tick();
        chk("t3_load_issue", {31'd0, issue_valid_out}, 32'd1);
        chk("t3_load_lsb", {31'd0, issue_to_lsb_out}, 32'd1);
        push1(32'h0020a223, 32'h204, 1'b1, 1'b1);
        tick();
        chk("t3_store_issue", {31'd0, issue_valid_out}, 32'd1);
        tick();

        // ---------------- rollback ----------------
        rs_full_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push1(alu_word(32'h300 + i), 32'h300 + 4 * i, 1'b0, 1'b1);
        end
        rollback_in        = 1'b1;
        rs_full_in         = 1'b0;
        fetch_valid_in     = 1'b1;
        fetch_inst_in      = alu_word(32'h3ff);
        fetch_pc_in        = 32'h3fc;
        tick();
        sbq.delete();
        rollback_in    = 1'b0;
        fetch_valid_in = 1'b0;
        chk("t4_rb_valid", {31'd0, issue_valid_out}, 32'd0);
        chk("t4_rb_dec", dec_inst_out, 32'd0);
        chk("t4_rb_full", {31'd0, iq_full_out}, 32'd0);
        push1(alu_word(32'h3aa), 32'h3a0, 1'b0, 1'b0);
        chk("t4_flush_push_ignored", dec_inst_out, 32'd0);
        chk("t4_flush_valid", {31'd0, issue_valid_out}, 32'd0);
        push1(alu_word(32'h3bb), 32'h3b0, 1'b1, 1'b1);
        chk("t4_post_flush_push", dec_inst_out, alu_word(32'h3bb));
        tick();
        chk("t4_post_flush_issue", {31'd0, issue_valid_out}, 32'd1);
`ifdef DISPATCH_STALL_CNT_EN
        chk("t4_flush_cnt", {16'd0, flush_cnt_out}, 32'd1);
`endif
        tick();

        // ---------------- illegal head then addi ----------------
        push1(32'h0, 32'h400, 1'b0, 1'b1);
        chk("t5_illegal_wait", {31'd0, issue_valid_out}, 32'd0);
        push1(alu_word(32'h5), 32'h404, 1'b0, 1'b1);
        chk("t5_illegal_dropped", {31'd0, issue_valid_out}, 32'd0);
        chk("t5_addi_head", dec_inst_out, alu_word(32'h5));
        tick();
        chk("t5_addi_issue", {31'd0, issue_valid_out}, 32'd1);
        chk("t5_addi_pc", issue_pc_out, 32'h404);
`ifdef DISPATCH_STALL_CNT_EN
        chk("t5_illegal_cnt", {16'd0, illegal_cnt_out}, 32'd1);
        chk("t5_stall_cnt_nz", {31'd0, stall_cnt_out != 32'd0}, 32'd1);
`endif
        tick();

        // ---------------- pause mid-stream ----------------
        rs_full_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push1(alu_word(32'h500 + i), 32'h500 + 4 * i, 1'b0, 1'b1);
        end
        rs_full_in = 1'b0;
        tick();
        chk("t6_first_issue", {31'd0, issue_valid_out}, 32'd1);
        rdy_in             = 1'b0;
        rollback_in        = 1'b1;
        fetch_valid_in     = 1'b1;
        fetch_inst_in      = alu_word(32'h5ff);
        fetch_pc_in        = 32'h5f0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_hold_valid", {31'd0, issue_valid_out}, 32'd1);
            chk("t6_hold_pc", issue_pc_out, 32'h500);
            chk("t6_hold_head", dec_inst_out, alu_word(32'h501));
        end
        rdy_in         = 1'b1;
        rollback_in    = 1'b0;
        fetch_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_resume_valid", {31'd0, issue_valid_out}, 32'd1);
        end
        tick();
        chk("t6_done", {31'd0, issue_valid_out}, 32'd0);

        // ---------------- asynchronous reset mid-run ----------------
        rs_full_in = 1'b1;
        push1(alu_word(32'h600), 32'h600, 1'b0, 1'b1);
        push1(alu_word(32'h601), 32'h604, 1'b0, 1'b1);
        #2 rst_n_in = 1'b0;
        #1;
        sbq.delete();
        chk("t7_async_dec", dec_inst_out, 32'd0);
        chk("t7_async_valid", {31'd0, issue_valid_out}, 32'd0);
        tick();
        rs_full_in = 1'b0;
        rst_n_in   = 1'b1;
        push1(alu_word(32'h700), 32'h700, 1'b1, 1'b1);
        chk("t7_first_push", dec_inst_out, alu_word(32'h700));
        tick();
        chk("t7_issue", {31'd0, issue_valid_out}, 32'd1);
        tick();
        tick();

        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
